// File: rtl/pipe_ctrl_if.sv
// Stall/flush bundle between pipe_ctrl (master) and the pipeline registers / IF unit (slave).
interface pipe_ctrl_if #(
   parameter int STALL_W = 6
);
   logic               stallreq_if;
   logic               stallreq_id;
   logic               stallreq_ex;
   logic               stallreq_mem;
   logic               ex_b_flag;
   logic [31:0]        ex_b_target;
   logic               redirect_ready;
   logic [STALL_W-1:0] stall_state;
   logic               b_flag_o;
   logic               redirect_valid;
   logic [31:0]        redirect_pc;

   modport master (
      input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
      input  ex_b_flag, ex_b_target, redirect_ready,
      output stall_state, b_flag_o, redirect_valid, redirect_pc
   );

   modport slave (
      output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
      output ex_b_flag, ex_b_target, redirect_ready,
      input  stall_state, b_flag_o, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges stage stall requests, qualifies EX mispredicts, holds redirect PC.
// Optional performance counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
   parameter int STALL_W   = 6,
   parameter int MAX_STALL = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   pipe_ctrl_if.master bus,
   output logic        stall_timeout,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
);
   typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;

   localparam logic [15:0] MAX_CNT = 16'(MAX_STALL);

   state_t             state;
   logic               redirect_valid;
   logic [31:0]        redirect_pc;
   logic [15:0]        mem_cnt;
   logic [15:0]        mem_cnt_next;
   logic [STALL_W-1:0] stall_state;
   logic               b_flag;

   always_comb begin
      stall_state = '0;
      if (bus.stallreq_mem)     stall_state[3:0] = 4'b1111;
      else if (bus.stallreq_ex) stall_state[2:0] = 3'b111;
      else if (bus.stallreq_id) stall_state[1:0] = 2'b11;
      else if (bus.stallreq_if) stall_state[0]   = 1'b1;
      // PC stays frozen until IF takes the redirect
      if (state == REDIRECT)    stall_state[0]   = 1'b1;
   end

   // A held EX stage re-presents its branch next cycle, so only a moving EX may flush.
   assign b_flag = bus.ex_b_flag & ~bus.stallreq_mem & ~bus.stallreq_ex;

   assign bus.stall_state    = stall_state;
   assign bus.b_flag_o       = b_flag;
   assign bus.redirect_valid = redirect_valid;
   assign bus.redirect_pc    = redirect_pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= RUN;
         redirect_valid <= 1'b0;
         redirect_pc    <= 32'h0;
      end else if (rdy) begin
         case (state)
            RUN, MEM_WAIT: begin
               if (b_flag) begin
                  redirect_pc    <= bus.ex_b_target;
                  redirect_valid <= 1'b1;
                  state          <= REDIRECT;
               end else if (bus.stallreq_mem) begin
                  state <= MEM_WAIT;
               end else begin
                  state <= RUN;
               end
            end
            REDIRECT: begin
               // a fresh flush supersedes the pending target even if IF acks this cycle
               if (b_flag) begin
                  redirect_pc <= bus.ex_b_target;
               end else if (bus.redirect_ready) begin
                  redirect_valid <= 1'b0;
                  state          <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   assign mem_cnt_next = (mem_cnt == 16'hFFFF) ? mem_cnt : mem_cnt + 16'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_cnt       <= 16'h0;
         stall_timeout <= 1'b0;
      end else if (rdy) begin
         if (bus.stallreq_mem) begin
            mem_cnt <= mem_cnt_next;
            if (mem_cnt_next >= MAX_CNT) stall_timeout <= 1'b1;
         end else begin
            mem_cnt <= 16'h0;
         end
      end
   end

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_cnt <= 32'h0;
         perf_flush_cnt <= 32'h0;
      end else if (rdy) begin
         if (|stall_state) perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (b_flag)       perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`else
   assign perf_stall_cnt = 32'h0;
   assign perf_flush_cnt = 32'h0;
`endif
endmodule
